// File: rtl/bcd_field_counter_pkg.sv
// Shared types, constants and helpers for the BCD field counter slice.
package bcd_field_counter_pkg;

  localparam int unsigned DIG_W    = 4;
  localparam int unsigned MAX_NDIG = 8;
  localparam logic [DIG_W-1:0] BCD_NINE = 4'd9;

  typedef enum logic {
    RPT_DELAY  = 1'b0,
    RPT_REPEAT = 1'b1
  } rpt_phase_e;

  // Binary integer to packed BCD, used for elaboration-time constants.
  function automatic logic [MAX_NDIG*DIG_W-1:0] to_bcd(input int unsigned bin);
    logic [MAX_NDIG*DIG_W-1:0] res;
    int unsigned               v;
    res = '0;
    v   = bin;
    for (int unsigned i = 0; i < MAX_NDIG; i++) begin
      res[DIG_W*i +: DIG_W] = DIG_W'(v % 10);
      v = v / 10;
    end
    return res;
  endfunction

endpackage

// File: rtl/bcd_field_counter_if.sv
// Per-field bus: chain carry, edit buttons/mode, dynamic bound and field outputs.
interface bcd_field_counter_if #(
  parameter int unsigned NDIG = 2
);
  localparam int unsigned W = 4 * NDIG;

  logic         inc_in;
  logic         btn_up;
  logic         btn_down;
  logic [2:0]   mode;
  logic [W-1:0] max_in;
  logic [W-1:0] val;
  logic         carry_out;
  logic         edited;

  modport master (
    output inc_in, btn_up, btn_down, mode, max_in,
    input  val, carry_out, edited
  );

  modport slave (
    input  inc_in, btn_up, btn_down, mode, max_in,
    output val, carry_out, edited
  );
endinterface

// File: rtl/bcd_field_counter_step.sv
// Combinational packed-BCD +/-1 (dir=0 up, dir=1 down), wrapping at the digit range.
module bcd_field_counter_step
  import bcd_field_counter_pkg::*;
#(
  parameter int unsigned NDIG = 2
) (
  input  logic                  dir,
  input  logic [DIG_W*NDIG-1:0] val_i,
  output logic [DIG_W*NDIG-1:0] res_c
);

  for (genvar i = 0; i < NDIG; i++) begin : g_dig
    logic             cin_c;
    logic [DIG_W-1:0] nib_c;

    // Carry/borrow into digit i: every lower digit is saturated (9 up, 0 down).
    always_comb begin
      cin_c = 1'b1;
      for (int unsigned j = 0; j < i; j++) begin
        cin_c = cin_c & (dir ? (val_i[DIG_W*j +: DIG_W] == '0)
                             : (val_i[DIG_W*j +: DIG_W] == BCD_NINE));
      end
      nib_c = val_i[DIG_W*i +: DIG_W];
      if (cin_c) begin
        if (dir) nib_c = (nib_c == '0) ? BCD_NINE : nib_c - DIG_W'(1);
        else     nib_c = (nib_c >= BCD_NINE) ? '0 : nib_c + DIG_W'(1);
      end
    end

    assign res_c[DIG_W*i +: DIG_W] = nib_c;
  end

endmodule

// File: rtl/bcd_field_counter.sv
// One BCD time/date field: counts chain ticks, wraps with carry, and supports button editing.
module bcd_field_counter
  import bcd_field_counter_pkg::*;
#(
  parameter int unsigned NDIG       = 2,
  parameter int unsigned MIN_VAL    = 0,
  parameter int unsigned MAX_VAL    = 23,
  parameter bit          USE_MAX_IN = 1'b0,
  parameter logic [2:0]  MODE_ID    = 3'b010,
  parameter int unsigned RPT_DLY    = 2,
  parameter int unsigned RPT_RATE   = 1
) (
  input  logic clk_1Hz,
  input  logic rst_n,
  bcd_field_counter_if.slave bus
);

  localparam int unsigned W       = DIG_W * NDIG;
  localparam int unsigned RPT_MAX = (RPT_DLY + 1 > RPT_RATE) ? RPT_DLY + 1 : RPT_RATE;
  localparam int unsigned CNT_W   = $clog2(RPT_MAX + 1);
  localparam logic [W-1:0] MIN_BCD = W'(to_bcd(MIN_VAL));
  localparam logic [W-1:0] MAX_BCD = W'(to_bcd(MAX_VAL));

  logic [W-1:0]     val_q, val_d;
  logic             carry_q, carry_d;
  logic             edited_q, edited_d;
  logic [CNT_W-1:0] rpt_q, rpt_d, rpt_n, rpt_thr;
  rpt_phase_e       phase_q, phase_d;
  logic             up_hi_q, up_hi_d, dn_hi_q, dn_hi_d;
  logic             up_arm_q, up_arm_d, dn_arm_q, dn_arm_d;

  logic [W-1:0] eff_max, inc_val, dec_val;
  logic         edit, up_lo, dn_lo, up_edge, dn_edge, up_held, dn_held, step;

  bcd_field_counter_step #(.NDIG(NDIG)) u_inc (.dir(1'b0), .val_i(val_q), .res_c(inc_val));
  bcd_field_counter_step #(.NDIG(NDIG)) u_dec (.dir(1'b1), .val_i(val_q), .res_c(dec_val));

  assign eff_max = USE_MAX_IN ? bus.max_in : MAX_BCD;
  assign edit    = (~bus.mode == MODE_ID);
  assign up_lo   = ~bus.btn_up;
  assign dn_lo   = ~bus.btn_down;
  // A held button only acts once it has been seen released since reset.
  assign up_edge = up_lo & up_hi_q;
  assign dn_edge = dn_lo & dn_hi_q;
  assign up_held = up_lo & ~up_hi_q & up_arm_q;
  assign dn_held = dn_lo & ~dn_hi_q & dn_arm_q;
  assign rpt_thr = (phase_q == RPT_DELAY) ? CNT_W'(RPT_DLY + 1) : CNT_W'(RPT_RATE);

  always_comb begin
    val_d    = val_q;
    carry_d  = 1'b0;
    edited_d = 1'b0;
    rpt_d    = rpt_q;
    phase_d  = phase_q;
    up_hi_d  = bus.btn_up;
    dn_hi_d  = bus.btn_down;
    up_arm_d = up_arm_q | bus.btn_up;
    dn_arm_d = dn_arm_q | bus.btn_down;
    step     = 1'b0;
    rpt_n    = rpt_q + CNT_W'(1);

    // Step generation: press edge steps at once, a hold repeats after delay then at rate.
    if (!edit || (up_lo && dn_lo) || !(up_lo || dn_lo)) begin
      rpt_d   = '0;
      phase_d = RPT_DELAY;
    end else if (up_edge || dn_edge) begin
      step    = 1'b1;
      rpt_d   = '0;
      phase_d = RPT_DELAY;
    end else if (up_held || dn_held) begin
      if (rpt_n == rpt_thr) begin
        step    = 1'b1;
        rpt_d   = '0;
        phase_d = RPT_REPEAT;
      end else begin
        rpt_d = rpt_n;
      end
    end

    // Value update; a shrunken bound clamps before anything else.
    if (val_q > eff_max) begin
      val_d = eff_max;
    end else if (edit) begin
      if (step) begin
        edited_d = 1'b1;
        if (dn_lo) val_d = (val_q == MIN_BCD) ? eff_max : dec_val;
        else       val_d = (val_q == eff_max) ? MIN_BCD : inc_val;
      end
    end else if (bus.inc_in) begin
      if (val_q == eff_max) begin
        val_d   = MIN_BCD;
        carry_d = 1'b1;
      end else begin
        val_d = inc_val;
      end
    end
  end

  always_ff @(posedge clk_1Hz or negedge rst_n) begin
    if (!rst_n) begin
      val_q    <= MIN_BCD;
      carry_q  <= 1'b0;
      edited_q <= 1'b0;
      rpt_q    <= '0;
      phase_q  <= RPT_DELAY;
      up_hi_q  <= 1'b0;
      dn_hi_q  <= 1'b0;
      up_arm_q <= 1'b0;
      dn_arm_q <= 1'b0;
    end else begin
      val_q    <= val_d;
      carry_q  <= carry_d;
      edited_q <= edited_d;
      rpt_q    <= rpt_d;
      phase_q  <= phase_d;
      up_hi_q  <= up_hi_d;
      dn_hi_q  <= dn_hi_d;
      up_arm_q <= up_arm_d;
      dn_arm_q <= dn_arm_d;
    end
  end

  assign bus.val       = val_q;
  assign bus.carry_out = carry_q;
  assign bus.edited    = edited_q;

endmodule

// File: tb/tb_bcd_field_counter.sv
// Directed bench for bcd_field_counter: hour field, 1..12 field and a dynamic-bound day field.
module tb_bcd_field_counter;

  logic        clk_1Hz = 1'b0;
  logic        rst_n;
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk_1Hz = ~clk_1Hz;

  bcd_field_counter_if #(.NDIG(2)) if0 ();
  bcd_field_counter_if #(.NDIG(2)) if1 ();
  bcd_field_counter_if #(.NDIG(2)) if2 ();

  bcd_field_counter #(.NDIG(2), .MIN_VAL(0), .MAX_VAL(23), .USE_MAX_IN(1'b0),
                      .MODE_ID(3'b010), .RPT_DLY(2), .RPT_RATE(1))
    u_hour (.clk_1Hz(clk_1Hz), .rst_n(rst_n), .bus(if0));

  bcd_field_counter #(.NDIG(2), .MIN_VAL(1), .MAX_VAL(12), .USE_MAX_IN(1'b0),
                      .MODE_ID(3'b101), .RPT_DLY(2), .RPT_RATE(1))
    u_mon (.clk_1Hz(clk_1Hz), .rst_n(rst_n), .bus(if1));

  bcd_field_counter #(.NDIG(2), .MIN_VAL(1), .MAX_VAL(31), .USE_MAX_IN(1'b1),
                      .MODE_ID(3'b100), .RPT_DLY(2), .RPT_RATE(1))
    u_day (.clk_1Hz(clk_1Hz), .rst_n(rst_n), .bus(if2));

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_1Hz);
    #1;
  endtask

  logic [7:0] hold_v  [6] = '{8'h01, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04};
  logic [7:0] hold_ed [6] = '{8'h01, 8'h00, 8'h00, 8'h01, 8'h01, 8'h01};

  initial begin
    rst_n = 1'b0;
    if0.inc_in = 1'b0; if0.btn_up = 1'b1; if0.btn_down = 1'b1; if0.mode = 3'b111; if0.max_in = 8'h00;
    if1.inc_in = 1'b0; if1.btn_up = 1'b1; if1.btn_down = 1'b1; if1.mode = 3'b111; if1.max_in = 8'h00;
    if2.inc_in = 1'b0; if2.btn_up = 1'b1; if2.btn_down = 1'b1; if2.mode = 3'b111; if2.max_in = 8'h31;
    repeat (2) step();
    chk("rst_hour_val", if0.val, 8'h00);
    chk("rst_hour_carry", 8'(if0.carry_out), 8'h00);
    chk("rst_hour_edited", 8'(if0.edited), 8'h00);
    chk("rst_mon_val", if1.val, 8'h01);
    chk("rst_day_val", if2.val, 8'h01);
    rst_n = 1'b1;

    // Hour chain counting and wrap.
    if0.inc_in = 1'b1;
    for (int i = 0; i < 23; i++) step();
    chk("hour_at_23", if0.val, 8'h23);
    chk("hour_no_carry_23", 8'(if0.carry_out), 8'h00);
    step();
    chk("hour_wrap_val", if0.val, 8'h00);
    chk("hour_wrap_carry", 8'(if0.carry_out), 8'h01);
    if0.inc_in = 1'b0;
    step();
    chk("hour_carry_1cyc", 8'(if0.carry_out), 8'h00);
    chk("hour_hold_val", if0.val, 8'h00);

    // 1..12 field: digit carry and wrap to MIN_VAL.
    if1.inc_in = 1'b1;
    for (int i = 0; i < 8; i++) step();
    chk("mon_at_09", if1.val, 8'h09);
    step();
    chk("mon_digit_carry", if1.val, 8'h10);
    repeat (2) step();
    chk("mon_at_12", if1.val, 8'h12);
    chk("mon_no_carry_12", 8'(if1.carry_out), 8'h00);
    step();
    chk("mon_wrap_val", if1.val, 8'h01);
    chk("mon_wrap_carry", 8'(if1.carry_out), 8'h01);
    if1.inc_in = 1'b0;
    step();
    chk("mon_carry_1cyc", 8'(if1.carry_out), 8'h00);

    // Edit mode: down tap wraps min->max without carry.
    if0.mode = 3'b101;
    step();
    chk("edit_idle_val", if0.val, 8'h00);
    if0.btn_down = 1'b0;
    step();
    chk("edit_down_wrap", if0.val, 8'h23);
    chk("edit_down_carry", 8'(if0.carry_out), 8'h00);
    chk("edit_down_edited", 8'(if0.edited), 8'h01);
    if0.btn_down = 1'b1;
    step();
    chk("edit_edited_1cyc", 8'(if0.edited), 8'h00);
    if0.inc_in = 1'b1;
    step();
    chk("edit_ignores_inc", if0.val, 8'h23);
    chk("edit_inc_no_carry", 8'(if0.carry_out), 8'h00);
    if0.inc_in = 1'b0;

    // Up tap wraps max->min, then hold with auto-repeat.
    if0.btn_up = 1'b0;
    step();
    chk("edit_up_wrap", if0.val, 8'h00);
    chk("edit_up_carry", 8'(if0.carry_out), 8'h00);
    if0.btn_up = 1'b1;
    step();
    if0.btn_up = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("hold_val_c%0d", i + 1), if0.val, hold_v[i]);
      chk($sformatf("hold_edited_c%0d", i + 1), 8'(if0.edited), hold_ed[i]);
    end
    if0.btn_down = 1'b0;
    step();
    chk("both_low_val", if0.val, 8'h04);
    chk("both_low_edited", 8'(if0.edited), 8'h00);
    step();
    chk("both_low_val2", if0.val, 8'h04);
    if0.btn_down = 1'b1;
    step();
    chk("release_one_no_edge", if0.val, 8'h04);
    if0.btn_up = 1'b1;
    step();

    // Dynamic bound: clamp beats inc_in, then wrap at the new bound.
    if2.inc_in = 1'b1;
    for (int i = 0; i < 30; i++) step();
    chk("day_at_31", if2.val, 8'h31);
    if2.max_in = 8'h28;
    step();
    chk("day_clamp_val", if2.val, 8'h28);
    chk("day_clamp_carry", 8'(if2.carry_out), 8'h00);
    chk("day_clamp_edited", 8'(if2.edited), 8'h00);
    step();
    chk("day_wrap_val", if2.val, 8'h01);
    chk("day_wrap_carry", 8'(if2.carry_out), 8'h01);
    if2.inc_in = 1'b0;

    // Async reset mid-hold; a button held through reset does not step.
    if0.btn_up = 1'b0;
    step();
    chk("pre_rst_step", if0.val, 8'h05);
    step();
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_hour", if0.val, 8'h00);
    chk("async_rst_edited", 8'(if0.edited), 8'h00);
    chk("async_rst_day", if2.val, 8'h01);
    @(posedge clk_1Hz);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("post_rst_held_c%0d", i + 1), if0.val, 8'h00);
    end
    if0.btn_up = 1'b1;
    step();
    if0.btn_up = 1'b0;
    step();
    chk("post_rst_fresh_press", if0.val, 8'h01);
    if0.btn_up = 1'b1;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
